// File: rtl/debounce_scheduler.sv
// Multi-button debouncer: one stability counter and qualification FSM shared
// round-robin across all raw button inputs.
module debounce_scheduler #(
   parameter int unsigned NUM_BTN = 4,
   parameter int unsigned N       = 10,
   localparam int unsigned CW     = $clog2(N) + 1,
   localparam int unsigned IW     = $clog2(NUM_BTN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn,
   output logic [NUM_BTN-1:0] btn_out,
   output logic [NUM_BTN-1:0] press_pulse,
   output logic [NUM_BTN-1:0] release_pulse,
   output logic               busy,
   output logic [IW-1:0]      cur_idx,
   output logic [CW-1:0]      counter
);

   typedef enum logic [1:0] {StIdle, StQualify, StCommit} state_e;

   state_e             state_q, state_d;
   logic [NUM_BTN-1:0] s1_q, s2_q;
   logic [NUM_BTN-1:0] btn_out_q, btn_out_d;
   logic [NUM_BTN-1:0] press_q, press_d;
   logic [NUM_BTN-1:0] release_q, release_d;
   logic [CW-1:0]      counter_q, counter_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic               target_q, target_d;

   logic [NUM_BTN-1:0] mismatch;
   logic [IW-1:0]      sel;
   logic               sel_valid;
   logic [IW-1:0]      next_idx;
   int unsigned        j;

   assign mismatch = s2_q ^ btn_out_q;
   assign next_idx = (idx_q == IW'(NUM_BTN - 1)) ? '0 : idx_q + 1'b1;

   // First pending button at or after the round-robin pointer.
   always_comb begin
      sel       = '0;
      sel_valid = 1'b0;
      j         = 0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
         j = (32'(ptr_q) + i) % NUM_BTN;
         if (!sel_valid && mismatch[IW'(j)]) begin
            sel_valid = 1'b1;
            sel       = IW'(j);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      target_d  = target_q;
      btn_out_d = btn_out_q;
      press_d   = '0;
      release_d = '0;
      case (state_q)
         StIdle: begin
            if (sel_valid) begin
               idx_d     = sel;
               target_d  = s2_q[sel];
               counter_d = '0;
               state_d   = StQualify;
            end
         end
         StQualify: begin
            // A bounce abandons this button and moves the pointer past it.
            if (s2_q[idx_q] != target_q) begin
               state_d   = StIdle;
               counter_d = '0;
               ptr_d     = next_idx;
            end else if (counter_q == CW'(N - 1)) begin
               state_d = StCommit;
            end else begin
               counter_d = counter_q + 1'b1;
            end
         end
         StCommit: begin
            btn_out_d[idx_q] = target_q;
            press_d[idx_q]   = target_q;
            release_d[idx_q] = ~target_q;
            ptr_d            = next_idx;
            counter_d        = '0;
            state_d          = StIdle;
         end
         default: begin
            state_d   = StIdle;
            counter_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         s1_q      <= '0;
         s2_q      <= '0;
         btn_out_q <= '0;
         press_q   <= '0;
         release_q <= '0;
         counter_q <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
         target_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         s1_q      <= btn;
         s2_q      <= s1_q;
         btn_out_q <= btn_out_d;
         press_q   <= press_d;
         release_q <= release_d;
         counter_q <= counter_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         target_q  <= target_d;
      end
   end

   assign btn_out       = btn_out_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign busy          = (state_q == StQualify) || (state_q == StCommit);
   assign cur_idx       = idx_q;
   assign counter       = counter_q;

endmodule
